bidir_dir_ctrl: RTL
===================

Name: bidir_dir_ctrl

Overview:
Direction controller and arbiter for a shared half-duplex bidirectional buffer (one A<->B bus pair). Two requesters, side A and side B, each ask to drive the pair. The block grants ownership round-robin and drives separate active-high direction enables. It inserts dead turnaround cycles, with both enables low, between ownership changes so the two drivers never overlap. It sits beside the buffer and replaces the single shared direction control with sequenced enables.

Parameters:
TURN_CYC, 2, dead cycles (both enables low) after any release; legal range 1..15
MAX_HOLD, 16, max cycles one side may own while the other side is requesting; legal range 2..255
CNT_W, 8, width of the hold and turnaround counters; must hold MAX_HOLD-1 and TURN_CYC-1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
req_a  input  1  side A requests to drive A->B
req_b  input  1  side B requests to drive B->A
gnt_a  output  1  A owns the bus; registered
gnt_b  output  1  B owns the bus; registered
en_a2b  output  1  enable for the A->B driver; equals gnt_a
en_b2a  output  1  enable for the B->A driver; equals gnt_b
turn  output  1  high during turnaround dead cycles
busy  output  1  high in any state other than IDLE

Behaviour:
- One clock; reset is synchronous and active-high. Signals are named clk and rst.
- All outputs are registered from state. At gnt_a=gnt_b=en_*=turn=busy=0 is the reset state; the last-served register resets to B, so A wins the first tie.
- States:
  - IDLE: no grants.
  - OWN_A: gnt_a=en_a2b=1.
  - OWN_B: gnt_b=en_b2a=1.
  - TURN: all enables 0, turn=1.
- Invariant: gnt_a & gnt_b is never 1. From reset onward, an enable never rises in the cycle right after the other enable falls.
- Arbitration function, evaluated in IDLE and in the last TURN cycle:
  - Only one request high: grant that side.
  - Both requests high: grant the side opposite the last-served side.
  - Neither request high: go to IDLE.
  - On any grant, last_served is updated to the granted side.
- IDLE -> OWN_x: a request sampled in cycle n gives gnt in cycle n+1 (1-cycle latency).
- OWN_A:
  - hold_cnt clears on entry and increments each cycle, saturating at MAX_HOLD-1.
  - Go to TURN when req_a=0 is sampled.
  - Also go to TURN when hold_cnt==MAX_HOLD-1 and req_b=1 (forced release).
  - If req_b=0, A keeps ownership indefinitely; hold_cnt stays saturated.
  - OWN_B is symmetric.
- TURN:
  - t_cnt clears on entry. The state lasts exactly TURN_CYC cycles.
  - In the last TURN cycle the arbitration function chooses the next state.
  - The same side may reacquire; turnaround still applies.
- Release to regrant: ownership ends in cycle n. TURN covers cycles n+1..n+TURN_CYC. The next grant appears at cycle n+TURN_CYC+1.
- Requests that drop during TURN are ignored until the final TURN cycle. Only the final-cycle sample counts.
- Reset mid-operation: the next edge forces IDLE with all outputs 0 and last_served=B, regardless of state or counters. No turnaround is inserted after reset.
- Requests are level-sensitive. Requesters hold req until they see gnt and drop req when done. A req held after a forced release is treated as a new request.

Test Plan:
1. Reset, then req_a=1 at cycle 3 -> gnt_a=en_a2b=1 at cycle 4; busy=1; gnt_b, en_b2a and turn stay 0.
2. A owns; req_a drops at cycle 10, req_b=1 (TURN_CYC=2) -> turn=1 at cycles 11-12, both enables 0; gnt_b=1 at cycle 13.
3. From IDLE after reset, req_a=req_b=1 in the same cycle -> A granted first. After A releases and turnaround completes with both still requesting -> B granted, then A again (alternation).
4. A holds req_a=1, req_b=1 from A's grant cycle (MAX_HOLD=16) -> gnt_a stays high exactly 16 cycles. Then 2 turn cycles, then gnt_b. With req_b=0, gnt_a stays high for 100+ cycles.
5. rst=1 asserted mid-TURN and again mid-OWN_B -> all outputs 0 on the next edge. After rst drops with both requesting -> A granted one cycle later.
6. Random req_a/req_b for 10k cycles -> assert gnt_a&gnt_b never 1. Assert at least TURN_CYC zero-enable cycles between every fall of one enable and the rise of the other.

Source files
------------

// File: rtl/bidir_dir_ctrl.sv
// bidir_dir_ctrl: round-robin owner arbiter and direction-enable sequencer
// for one half-duplex A<->B buffer pair, with dead turnaround cycles.
//
// Ports:
//   clk, rst           : rising-edge clock, synchronous active-high reset
//   req_a, req_b       : level requests from side A / side B
//   gnt_a, gnt_b       : registered ownership grants
//   en_a2b, en_b2a     : driver enables (same as gnt_a / gnt_b)
//   turn               : high during turnaround dead cycles
//   busy               : high whenever not idle
module bidir_dir_ctrl #(
  parameter int TURN_CYC = 2,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic en_a2b,
  output logic en_b2a,
  output logic turn,
  output logic busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN_A = 2'd1;
  localparam logic [1:0] S_OWN_B = 2'd2;
  localparam logic [1:0] S_TURN  = 2'd3;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] TURN_LAST =
    CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] t_cnt;
  logic             last_b;

  logic gnt_a_q;
  logic gnt_b_q;
  logic turn_q;
  logic busy_q;

  logic arb_a;
  logic arb_b;
  logic [1:0] arb_state;
  logic hold_sat;
  logic t_last;
  logic rel_a;
  logic rel_b;
  logic enter_a;
  logic enter_b;
  logic enter_t;

  // Tie goes to the side that was not served last.
  assign arb_a = req_a & (~req_b | last_b);
  assign arb_b = req_b & (~req_a | ~last_b);

  always_comb begin
    arb_state = S_IDLE;
    unique case (1'b1)
      arb_a:   arb_state = S_OWN_A;
      arb_b:   arb_state = S_OWN_B;
      default: arb_state = S_IDLE;
    endcase
  end

  assign hold_sat = (hold_cnt == HOLD_LAST);
  assign t_last   = (t_cnt == TURN_LAST);

  // Owner lets go on its own, or is forced out once
  // the hold budget is used while the peer waits.
  assign rel_a = ~req_a | (hold_sat & req_b);
  assign rel_b = ~req_b | (hold_sat & req_a);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        state_nxt = arb_state;
      end
      S_OWN_A: begin
        if (rel_a) begin
          state_nxt = S_TURN;
        end
      end
      S_OWN_B: begin
        if (rel_b) begin
          state_nxt = S_TURN;
        end
      end
      S_TURN: begin
        if (t_last) begin
          state_nxt = arb_state;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign enter_a = (state_nxt == S_OWN_A) &
                   (state != S_OWN_A);
  assign enter_b = (state_nxt == S_OWN_B) &
                   (state != S_OWN_B);
  assign enter_t = (state_nxt == S_TURN) &
                   (state != S_TURN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (enter_a) begin
      last_b <= 1'b0;
    end else if (enter_b) begin
      last_b <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (enter_a | enter_b) begin
      hold_cnt <= '0;
    end else if (!hold_sat) begin
      hold_cnt <= hold_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_cnt <= '0;
    end else if (enter_t) begin
      t_cnt <= '0;
    end else if (state == S_TURN) begin
      t_cnt <= t_cnt + CNT_ONE;
    end
  end

  // Outputs are flops loaded from the next state so they
  // change cleanly on the clock edge with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      turn_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      gnt_a_q <= (state_nxt == S_OWN_A);
      gnt_b_q <= (state_nxt == S_OWN_B);
      turn_q  <= (state_nxt == S_TURN);
      busy_q  <= (state_nxt != S_IDLE);
    end
  end

  assign gnt_a  = gnt_a_q;
  assign gnt_b  = gnt_b_q;
  assign en_a2b = gnt_a_q;
  assign en_b2a = gnt_b_q;
  assign turn   = turn_q;
  assign busy   = busy_q;

endmodule
